// File: rtl/store_align_unit.sv
// rtl/store_align_unit.sv - memory-write stage: latches a store, aligns data/strobes and issues word write beats.
// Define KIANV_MISALIGNED_STORE_SPLIT_EN to split word-crossing stores into two beats instead of trapping.
`ifndef STORE_OP_WIDTH
`define STORE_OP_WIDTH 2
`endif
`ifndef STORE_OP_SB
`define STORE_OP_SB 2'd0
`endif
`ifndef STORE_OP_SH
`define STORE_OP_SH 2'd1
`endif
`ifndef STORE_OP_SW
`define STORE_OP_SW 2'd2
`endif

module store_align_unit (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [`STORE_OP_WIDTH-1:0] STOREop,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata_in,
  output logic                       busy,
  output logic                       done,
  output logic                       misaligned,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_wstrb
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, FIN} state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        mis_q, mis_d;
  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic [1:0]  off;
  logic [3:0]  base_strb;
  logic [31:0] masked;
  logic        illegal_op;
  logic [31:0] word_addr;
  logic [3:0]  lo_strb;
  logic [31:0] lo_data;

  assign off       = addr[1:0];
  assign word_addr = {addr[31:2], 2'b00};

  always_comb begin
    base_strb  = 4'b0000;
    masked     = 32'h0;
    illegal_op = 1'b0;
    case (STOREop)
      `STORE_OP_SB: begin
        base_strb = 4'b0001;
        masked    = {24'h0, wdata_in[7:0]};
      end
      `STORE_OP_SH: begin
        base_strb = 4'b0011;
        masked    = {16'h0, wdata_in[15:0]};
      end
      `STORE_OP_SW: begin
        base_strb = 4'b1111;
        masked    = wdata_in;
      end
      default: illegal_op = 1'b1;
    endcase
  end

`ifdef KIANV_MISALIGNED_STORE_SPLIT_EN
  // Upper half of the 64-bit shifted window feeds the second beat.
  logic [7:0]  strb8;
  logic [63:0] data64;
  logic [31:0] hi_addr_q, hi_addr_d;
  logic [31:0] hi_data_q, hi_data_d;
  logic [3:0]  hi_strb_q, hi_strb_d;

  assign strb8   = {4'b0000, base_strb} << off;
  assign data64  = {32'h0, masked} << {off, 3'b000};
  assign lo_strb = strb8[3:0];
  assign lo_data = data64[31:0];
`else
  logic mis_in;

  assign lo_strb = base_strb << off;
  assign lo_data = masked << {off, 3'b000};
  assign mis_in  = ((STOREop == `STORE_OP_SH) && addr[0]) ||
                   ((STOREop == `STORE_OP_SW) && (off != 2'b00));
`endif

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    valid_d = valid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
`ifdef KIANV_MISALIGNED_STORE_SPLIT_EN
    hi_addr_d = hi_addr_q;
    hi_data_d = hi_data_q;
    hi_strb_d = hi_strb_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (illegal_op) begin
            state_d = FIN;
            done_d  = 1'b1;
          end
`ifndef KIANV_MISALIGNED_STORE_SPLIT_EN
          else if (mis_in) begin
            state_d = FIN;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end
`endif
          else begin
            state_d = BEAT0;
            valid_d = 1'b1;
            addr_d  = word_addr;
            wstrb_d = lo_strb;
            wdata_d = lo_data;
`ifdef KIANV_MISALIGNED_STORE_SPLIT_EN
            hi_addr_d = word_addr + 32'd4;
            hi_strb_d = strb8[7:4];
            hi_data_d = data64[63:32];
`endif
          end
        end
      end
      BEAT0: begin
        if (mem_ready) begin
`ifdef KIANV_MISALIGNED_STORE_SPLIT_EN
          if (hi_strb_q != 4'b0000) begin
            state_d = BEAT1;
            addr_d  = hi_addr_q;
            wstrb_d = hi_strb_q;
            wdata_d = hi_data_q;
          end else
`endif
          begin
            state_d = FIN;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
`ifdef KIANV_MISALIGNED_STORE_SPLIT_EN
      BEAT1: begin
        if (mem_ready) begin
          state_d = FIN;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
      end
`endif
      FIN: state_d = IDLE;
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'b0000;
`ifdef KIANV_MISALIGNED_STORE_SPLIT_EN
      hi_addr_q <= 32'h0;
      hi_data_q <= 32'h0;
      hi_strb_q <= 4'b0000;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
`ifdef KIANV_MISALIGNED_STORE_SPLIT_EN
      hi_addr_q <= hi_addr_d;
      hi_data_q <= hi_data_d;
      hi_strb_q <= hi_strb_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign misaligned = mis_q;
  assign mem_valid  = valid_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;

endmodule
